// File: rtl/ej3_moore_pkg.sv
// Shared state encoding (y1 y0) for the "two consecutive ones" Moore detector.
package ej3_moore_pkg;

    localparam logic [1:0] ST_A      = 2'b00;
    localparam logic [1:0] ST_B      = 2'b01;
    localparam logic [1:0] ST_C      = 2'b10;
    localparam logic [1:0] ST_UNUSED = 2'b11;

    typedef enum logic [1:0] {
        S_A      = ST_A,
        S_B      = ST_B,
        S_C      = ST_C,
        S_UNUSED = ST_UNUSED
    } state_e;

endpackage

// File: rtl/first_comb_moore.sv
// Next-state gates; callers supply both polarities of every input.
module first_comb_moore (
    input  logic W,
    input  logic _W,
    input  logic y0,
    input  logic _y0,
    input  logic y1,
    input  logic _y1,
    output logic next_y0,
    output logic next_y1
);

    // next_y0 = W & ~y0 & ~y1 built as a NOR of the opposite rails
    assign next_y0 = ~(_W | y0 | y1);
    assign next_y1 = W & ~(_y0 & _y1);

endmodule

// File: rtl/second_comb_moore.sv
// Moore output gates: Z is asserted only in state C (y1=1, y0=0).
module second_comb_moore (
    input  logic y0,
    input  logic _y0,
    input  logic y1,
    input  logic _y1,
    output logic Z
);

    // Dual-rail form: both polarities of each state bit feed the decode
    assign Z = (y1 & _y0) & ~(y0 | _y1);

endmodule

// File: rtl/ej3_moore_fsm.sv
// Moore detector: Z=1 once W has been 1 on the two most recent rising edges.
module ej3_moore_fsm
    import ej3_moore_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic W,
    output logic y0,
    output logic y1,
    output logic Z
);

    state_e state_q;
    state_e state_d;

    logic w_n;
    logic y0_n;
    logic y1_n;
    logic next_y0;
    logic next_y1;

    assign w_n  = ~W;
    assign y0_n = ~state_q[0];
    assign y1_n = ~state_q[1];

    first_comb_moore u_next_state (
        .W       (W),
        ._W      (w_n),
        .y0      (state_q[0]),
        ._y0     (y0_n),
        .y1      (state_q[1]),
        ._y1     (y1_n),
        .next_y0 (next_y0),
        .next_y1 (next_y1)
    );

    second_comb_moore u_output (
        .y0  (state_q[0]),
        ._y0 (y0_n),
        .y1  (state_q[1]),
        ._y1 (y1_n),
        .Z   (Z)
    );

    always_comb begin
        state_d = S_A;
        state_d = state_e'({next_y1, next_y0});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    assign y0 = state_q[0];
    assign y1 = state_q[1];

endmodule

// File: tb/tb_ej3_moore_fsm.sv
// Bench for ej3_moore_fsm: run-length model plus directed literal vectors.
module tb_ej3_moore_fsm;
    import ej3_moore_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic W;
    logic y0, y1, Z;

    int n_checks = 0;
    int n_fail   = 0;

    logic chk_en    = 1'b0;
    logic in_unused = 1'b0;
    int   run_m;

    logic t_w, t_y0, t_y1;
    logic t_ny0, t_ny1, t_z;

    always #5 clk = ~clk;

    ej3_moore_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .W     (W),
        .y0    (y0),
        .y1    (y1),
        .Z     (Z)
    );

    first_comb_moore u_tt_next (
        .W       (t_w),
        ._W      (~t_w),
        .y0      (t_y0),
        ._y0     (~t_y0),
        .y1      (t_y1),
        ._y1     (~t_y1),
        .next_y0 (t_ny0),
        .next_y1 (t_ny1)
    );

    second_comb_moore u_tt_out (
        .y0  (t_y0),
        ._y0 (~t_y0),
        .y1  (t_y1),
        ._y1 (~t_y1),
        .Z   (t_z)
    );

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: number of consecutive ones seen, saturating at 2
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         run_m <= 0;
        else if (!W)        run_m <= 0;
        else if (in_unused) run_m <= 2;
        else                run_m <= (run_m >= 1) ? 2 : run_m + 1;
    end

    function automatic logic [1:0] run_to_state(input int run);
        if (run >= 2)      return ST_C;
        else if (run == 1) return ST_B;
        else               return ST_A;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_state", {y1, y0}, run_to_state(run_m));
            check("cycle_Z", {1'b0, Z}, {1'b0, run_m >= 2});
        end
    end

    task automatic step(input logic w, input logic [1:0] exp_st, input logic exp_z, input string tag);
        @(negedge clk);
        W = w;
        @(posedge clk);
        #1;
        check({tag, "_state"}, {y1, y0}, exp_st);
        check({tag, "_Z"}, {1'b0, Z}, {1'b0, exp_z});
        $display("step %s: W=%b y1y0=%b%b Z=%b", tag, w, y1, y0, Z);
    endtask

    initial begin
        logic [1:0] s;
        logic [1:0] exp_next;
        rst_n = 1'b0;
        W     = 1'b0;

        // Combinational truth tables from the transition rules
        for (int i = 0; i < 8; i++) begin
            {t_w, t_y1, t_y0} = 3'(i);
            #1;
            s = {t_y1, t_y0};
            exp_next = !t_w ? ST_A : ((s == ST_A) ? ST_B : ST_C);
            check("tt_next", {t_ny1, t_ny0}, exp_next);
            check("tt_Z", {1'b0, t_z}, {1'b0, s == ST_C});
            $display("tt W=%b y1y0=%b -> next=%b%b Z=%b", t_w, s, t_ny1, t_ny0, t_z);
        end

        check("reset_state", {y1, y0}, 2'b00);
        check("reset_Z", {1'b0, Z}, 2'b00);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        step(1'b1, 2'b01, 1'b0, "seq1");
        step(1'b1, 2'b10, 1'b1, "seq2");
        step(1'b1, 2'b10, 1'b1, "seq3");
        step(1'b0, 2'b00, 1'b0, "seq4");
        step(1'b1, 2'b01, 1'b0, "seq5");
        step(1'b1, 2'b10, 1'b1, "seq6");

        // Asynchronous reset mid-cycle while in C, W held high
        @(posedge clk);
        #2;
        W     = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", {y1, y0}, 2'b00);
        check("async_rst_Z", {1'b0, Z}, 2'b00);
        $display("async reset: y1y0=%b%b Z=%b", y1, y0, Z);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold_state", {y1, y0}, 2'b00);
        end
        @(negedge clk);
        W     = 1'b0;
        rst_n = 1'b1;

        step(1'b1, 2'b01, 1'b0, "brk1");
        step(1'b0, 2'b00, 1'b0, "brk2");
        step(1'b1, 2'b01, 1'b0, "brk3");
        step(1'b0, 2'b00, 1'b0, "brk4");

        // Unused state recovery, W=1 then W=0
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk_en = 1'b0;
            @(negedge clk);
            force dut.state_q = S_UNUSED;
            #1;
            check("forced_state", {y1, y0}, 2'b11);
            check("forced_Z", {1'b0, Z}, 2'b00);
            W         = (k == 0);
            in_unused = 1'b1;
            release dut.state_q;
            @(posedge clk);
            #1;
            in_unused = 1'b0;
            check("recover_state", {y1, y0}, (k == 0) ? 2'b10 : 2'b00);
            check("recover_Z", {1'b0, Z}, {1'b0, k == 0});
            $display("recover W=%b: y1y0=%b%b Z=%b", W, y1, y0, Z);
            chk_en = 1'b1;
        end

        step(1'b1, 2'b01, 1'b0, "post1");
        step(1'b1, 2'b10, 1'b1, "post2");
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
